// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : ex_muldiv_unit
// Brief   : EX-stage HI/LO unit: 1-cycle MULT/MULTU, restoring DIV/DIVU, MTxx/MFxx
// Revision: 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] HILO_RESET = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  stall_next_stage,
   input  logic [5:0]            ex_funct_i,
   input  logic [DATA_WIDTH-1:0] ex_operand_1_i,
   input  logic [DATA_WIDTH-1:0] ex_operand_2_i,
   output logic                  stall_request_o,
   output logic [DATA_WIDTH-1:0] hilo_result_o,
   output logic                  hilo_result_valid_o,
   output logic [DATA_WIDTH-1:0] hi_o,
   output logic [DATA_WIDTH-1:0] lo_o
);
   localparam int CW = $clog2(DATA_WIDTH);

   localparam logic [5:0] c_F_MFHI  = 6'h10;
   localparam logic [5:0] c_F_MTHI  = 6'h11;
   localparam logic [5:0] c_F_MFLO  = 6'h12;
   localparam logic [5:0] c_F_MTLO  = 6'h13;
   localparam logic [5:0] c_F_MULT  = 6'h18;
   localparam logic [5:0] c_F_MULTU = 6'h19;
   localparam logic [5:0] c_F_DIV   = 6'h1A;
   localparam logic [5:0] c_F_DIVU  = 6'h1B;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_BUSY = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam logic [CW-1:0] c_LAST = CW'(DATA_WIDTH - 1);

   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           count_q;
   logic [DATA_WIDTH-1:0]   hi_q, lo_q;
   logic [DATA_WIDTH-1:0]   rem_q, quo_q, dvs_q;
   logic                    qneg_q, rneg_q;

   logic                    w_adv, w_is_div, w_is_sdiv;
   logic                    w_start, w_div_commit;
   logic [2*DATA_WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
   logic [DATA_WIDTH:0]     w_shift, w_diff;
   logic [DATA_WIDTH-1:0]   w_abs1, w_abs2, w_quo_fix, w_rem_fix;

   assign w_adv     = !stall_next_stage && !flush;
   assign w_is_div  = (ex_funct_i == c_F_DIV) || (ex_funct_i == c_F_DIVU);
   assign w_is_sdiv = (ex_funct_i == c_F_DIV);

   // One 2W-bit multiplier serves both forms; sign extension selects MULT semantics.
   assign w_mul_a = {{DATA_WIDTH{(ex_funct_i == c_F_MULT) & ex_operand_1_i[DATA_WIDTH-1]}}, ex_operand_1_i};
   assign w_mul_b = {{DATA_WIDTH{(ex_funct_i == c_F_MULT) & ex_operand_2_i[DATA_WIDTH-1]}}, ex_operand_2_i};
   assign w_prod  = w_mul_a * w_mul_b;

   assign w_abs1 = (w_is_sdiv && ex_operand_1_i[DATA_WIDTH-1]) ? -ex_operand_1_i : ex_operand_1_i;
   assign w_abs2 = (w_is_sdiv && ex_operand_2_i[DATA_WIDTH-1]) ? -ex_operand_2_i : ex_operand_2_i;

   assign w_shift   = {rem_q, quo_q[DATA_WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, dvs_q};
   assign w_quo_fix = qneg_q ? -quo_q : quo_q;
   assign w_rem_fix = rneg_q ? -rem_q : rem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = c_IDLE;
      end else begin
         case (state_q)
            c_IDLE:  if (w_is_div) state_d = c_BUSY;
            c_BUSY:  if (count_q == c_LAST) state_d = c_DONE;
            c_DONE:  if (!stall_next_stage) state_d = c_IDLE;
            default: state_d = c_IDLE;
         endcase
      end
   end

   always_comb begin
      stall_request_o = 1'b0;
      w_start         = 1'b0;
      w_div_commit    = 1'b0;
      if (!rst && !flush) begin
         case (state_q)
            c_IDLE: begin
               stall_request_o = w_is_div;
               w_start         = w_is_div;
            end
            c_BUSY:  stall_request_o = 1'b1;
            c_DONE:  w_div_commit = !stall_next_stage;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q    <= HILO_RESET;
         lo_q    <= HILO_RESET;
         count_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         if (w_start) begin
            quo_q   <= w_abs1;
            dvs_q   <= w_abs2;
            rem_q   <= '0;
            count_q <= '0;
            qneg_q  <= w_is_sdiv && (ex_operand_1_i[DATA_WIDTH-1] ^ ex_operand_2_i[DATA_WIDTH-1]);
            rneg_q  <= w_is_sdiv && ex_operand_1_i[DATA_WIDTH-1];
         end else if (state_q == c_BUSY && !flush) begin
            // Restoring step: keep the trial difference only if it did not go negative.
            if (!w_diff[DATA_WIDTH]) begin
               rem_q <= w_diff[DATA_WIDTH-1:0];
               quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
               rem_q <= w_shift[DATA_WIDTH-1:0];
               quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
            count_q <= count_q + CW'(1);
         end

         if (w_div_commit) begin
            lo_q <= w_quo_fix;
            hi_q <= w_rem_fix;
         end else if (w_adv) begin
            case (ex_funct_i)
               c_F_MTHI:            hi_q <= ex_operand_1_i;
               c_F_MTLO:            lo_q <= ex_operand_1_i;
               c_F_MULT, c_F_MULTU: {hi_q, lo_q} <= w_prod;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      hilo_result_valid_o = (ex_funct_i == c_F_MFHI) || (ex_funct_i == c_F_MFLO);
      hilo_result_o       = '0;
      if (!rst) begin
         if (ex_funct_i == c_F_MFHI) hilo_result_o = hi_q;
         else if (ex_funct_i == c_F_MFLO) hilo_result_o = lo_q;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_muldiv_unit
// Brief   : Randomized self-checking bench for ex_muldiv_unit with directed pins
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    localparam logic [5:0] c_MFHI  = 6'h10;
    localparam logic [5:0] c_MTHI  = 6'h11;
    localparam logic [5:0] c_MFLO  = 6'h12;
    localparam logic [5:0] c_MTLO  = 6'h13;
    localparam logic [5:0] c_MULT  = 6'h18;
    localparam logic [5:0] c_MULTU = 6'h19;
    localparam logic [5:0] c_DIV   = 6'h1A;
    localparam logic [5:0] c_DIVU  = 6'h1B;
    localparam logic [5:0] c_NOP   = 6'h20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        stall_next_stage = 1'b0;
    logic [5:0]  ex_funct_i = c_NOP;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        stall_request_o;
    logic [31:0] hilo_result_o;
    logic        hilo_result_valid_o;
    logic [31:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.DATA_WIDTH(32), .HILO_RESET(32'h0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .stall_next_stage    (stall_next_stage),
        .ex_funct_i          (ex_funct_i),
        .ex_operand_1_i      (op1),
        .ex_operand_2_i      (op2),
        .stall_request_o     (stall_request_o),
        .hilo_result_o       (hilo_result_o),
        .hilo_result_valid_o (hilo_result_valid_o),
        .hi_o                (hi_o),
        .lo_o                (lo_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_div(input logic [5:0] f);
        return (f == c_DIV) || (f == c_DIVU);
    endfunction

    // Architectural divide result straight from integer arithmetic.
    function automatic void div_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'h0) begin
            q = (f == c_DIV && sa < 0) ? 32'h1 : 32'hFFFF_FFFF;
            r = a;
        end else if (f == c_DIVU) begin
            q = a / b;
            r = a % b;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Reference model state: HI/LO plus elapsed cycles of an outstanding divide.
    logic        m_init = 1'b0;
    logic [31:0] m_hi, m_lo, m_q, m_r;
    logic        m_busy = 1'b0;
    int          m_age  = 0;

    always @(negedge clk) begin
        logic [31:0] e_res;
        logic        e_valid, e_stall;
        logic [63:0] p;
        e_valid = (ex_funct_i == c_MFHI) || (ex_funct_i == c_MFLO);
        e_res   = 32'h0;
        if (!rst && ex_funct_i == c_MFHI) e_res = m_hi;
        if (!rst && ex_funct_i == c_MFLO) e_res = m_lo;
        e_stall = !rst && !flush && (m_busy ? (m_age <= 32) : is_div(ex_funct_i));
        check("stall_request", stall_request_o, e_stall);
        check("result_valid", hilo_result_valid_o, e_valid);
        check("hilo_result", hilo_result_o, e_res);
        if (m_init) begin
            check("hi", hi_o, m_hi);
            check("lo", lo_o, m_lo);
        end

        if (rst) begin
            m_hi = 32'h0; m_lo = 32'h0; m_busy = 1'b0; m_init = 1'b1;
        end else if (flush) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 33 && !stall_next_stage) begin
                m_lo = m_q; m_hi = m_r; m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end else if (is_div(ex_funct_i)) begin
            div_ref(ex_funct_i, op1, op2, m_q, m_r);
            m_busy = 1'b1;
            m_age  = 1;
        end else if (!stall_next_stage) begin
            case (ex_funct_i)
                c_MTHI: m_hi = op1;
                c_MTLO: m_lo = op1;
                c_MULT: begin
                    p = 64'(longint'($signed(op1)) * longint'($signed(op2)));
                    {m_hi, m_lo} = p;
                end
                c_MULTU: begin
                    p = {32'h0, op1} * {32'h0, op2};
                    {m_hi, m_lo} = p;
                end
                default: ;
            endcase
        end
    end

    // Holds the instruction in EX until it advances, counting stall cycles.
    task automatic exec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int stalls);
        @(posedge clk); #1;
        ex_funct_i = f; op1 = a; op2 = b;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_request_o && !stall_next_stage) begin
                @(posedge clk); #1;
                ex_funct_i = c_NOP;
                @(negedge clk); #1;
                return;
            end
            if (stall_request_o) stalls++;
            @(posedge clk); #1;
        end
        n_tests++; n_fail++;
        $display("FAIL exec_timeout: funct %h never advanced", f);
        ex_funct_i = c_NOP;
    endtask

    function automatic logic [5:0] pick_funct();
        logic [5:0] ops [10];
        ops = '{c_MFHI, c_MTHI, c_MFLO, c_MTLO, c_MULT, c_MULTU, c_DIV, c_DIVU, c_NOP, 6'h21};
        return ops[$urandom_range(0, 9)];
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int   sc;
        logic moved;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_stall", stall_request_o, 1'b0);
        check("reset_result", hilo_result_o, 32'h0);

        exec(c_MULT, 32'hFFFF_FFFF, 32'h2, sc);
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFFE);
        exec(c_MULTU, 32'hFFFF_FFFF, 32'h2, sc);
        check("multu_hi", hi_o, 32'h1);
        check("multu_lo", lo_o, 32'hFFFF_FFFE);

        exec(c_DIV, 32'hFFFF_FFF9, 32'h2, sc);
        check("div_stall_cycles", sc, 33);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);
        exec(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc);
        check("div_ovf_lo", lo_o, 32'h8000_0000);
        check("div_ovf_hi", hi_o, 32'h0);
        exec(c_DIVU, 32'h0000_ABCD, 32'h0, sc);
        check("divu0_stall_cycles", sc, 33);
        check("divu0_lo", lo_o, 32'hFFFF_FFFF);
        check("divu0_hi", hi_o, 32'h0000_ABCD);
        exec(c_DIV, 32'd5, 32'h0, sc);
        check("div0_lo", lo_o, 32'hFFFF_FFFF);
        check("div0_hi", hi_o, 32'd5);
        exec(c_DIVU, 32'd100, 32'd7, sc);
        check("divu_lo", lo_o, 32'd14);
        check("divu_hi", hi_o, 32'd2);

        // Flush part-way through a divide.
        @(posedge clk); #1;
        ex_funct_i = c_DIV; op1 = 32'd1000; op2 = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk); #1;
        check("flush_stall", stall_request_o, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; ex_funct_i = c_NOP;
        @(negedge clk); #1;
        check("post_flush_stall", stall_request_o, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk); #1;
        check("flush_lo_kept", lo_o, 32'd14);
        check("flush_hi_kept", hi_o, 32'd2);
        exec(c_DIVU, 32'd23, 32'd4, sc);
        check("after_flush_stall_cycles", sc, 33);
        check("after_flush_lo", lo_o, 32'd5);

        exec(c_MTHI, 32'h0000_1234, 32'h0, sc);
        @(posedge clk); #1;
        ex_funct_i = c_MFHI;
        @(negedge clk); #1;
        check("mfhi_result", hilo_result_o, 32'h0000_1234);
        check("mfhi_valid", hilo_result_valid_o, 1'b1);

        // MEM holds the divide in DONE for three cycles.
        @(posedge clk); #1;
        ex_funct_i = c_DIV; op1 = 32'd20; op2 = 32'd3; stall_next_stage = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_request_o) break;
        end
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_lo", lo_o, 32'd5);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        stall_next_stage = 1'b0;
        @(posedge clk); #1;
        ex_funct_i = c_NOP;
        @(negedge clk); #1;
        check("release_lo", lo_o, 32'd6);
        check("release_hi", hi_o, 32'd2);

        // Reset mid-divide.
        @(posedge clk); #1;
        ex_funct_i = c_DIV; op1 = 32'd99; op2 = 32'd5;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ex_funct_i = c_NOP;
        @(negedge clk); #1;
        check("rst_mid_hi", hi_o, 32'h0);
        check("rst_mid_lo", lo_o, 32'h0);
        check("rst_mid_stall", stall_request_o, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk); #1;
        check("rst_mid_lo_later", lo_o, 32'h0);

        // Randomized pipeline traffic; the negedge model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            moved = rst || flush || (!stall_next_stage && !stall_request_o);
            @(posedge clk); #1;
            rst              = ($urandom_range(0, 299) == 0);
            flush            = ($urandom_range(0, 59) == 0);
            stall_next_stage = ($urandom_range(0, 5) == 0);
            if (moved) begin
                ex_funct_i = pick_funct();
                op1 = rnd_op();
                op2 = rnd_op();
            end else if (is_div(ex_funct_i)) begin
                op1 = rnd_op();
                op2 = rnd_op();
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; stall_next_stage = 1'b0; ex_funct_i = c_NOP;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
